// File: rtl/score_ssd_driver.sv
// score_ssd_driver
// Converts a 16-bit binary score into four decimal digits using a free-running
// sequential double-dabble engine (LOAD, SHIFT x16, COMMIT), saturates at 9999,
// and scans the digits onto an active-low 4-anode / 7-segment display.
module score_ssd_driver #(
  parameter int unsigned SCAN_BITS = 18,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] score,
  output logic [6:0]  ssdOut,
  output logic [3:0]  anode,
  output logic        overflow,
  output logic        conv_done
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [15:0]            r_bin;
  logic [19:0]            r_bcd;
  logic [4:0]             r_cnt;
  logic [15:0]            r_digits;   // {thousands, hundreds, tens, ones}
  logic [SCAN_BITS-1:0]   r_scan;

  logic [19:0]            w_bcd_adj;
  logic [1:0]             w_sel;
  logic [3:0]             w_digit;
  logic [3:0]             w_anode;
  logic                   w_blank;
  logic [6:0]             w_seg;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: capture, 16 shift steps, then commit all digits at once.
  // The ten-thousands nibble being non-zero is equivalent to score > 9999.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_LOAD;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_digits  <= '0;
      overflow  <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_bin   <= score;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[18:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            r_state   <= S_COMMIT;
            conv_done <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (r_bcd[19:16] != 4'd0) begin
            r_digits <= 16'h9999;
            overflow <= 1'b1;
          end else begin
            r_digits <= r_bcd[15:0];
            overflow <= 1'b0;
          end
          r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Free-running refresh counter; its top two bits pick the active digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign w_sel = r_scan[SCAN_BITS-1 -: 2];

  // Digit/anode selection with leading-zero blanking of the upper slots.
  always_comb begin
    w_digit = r_digits[3:0];
    w_anode = 4'b1110;
    w_blank = 1'b0;
    case (w_sel)
      2'd0: begin
        w_digit = r_digits[3:0];
        w_anode = 4'b1110;
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_digits[7:4];
        w_anode = 4'b1101;
        w_blank = BLANK_LZ && (r_digits[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit = r_digits[11:8];
        w_anode = 4'b1011;
        w_blank = BLANK_LZ && (r_digits[15:8] == 8'd0);
      end
      default: begin
        w_digit = r_digits[15:12];
        w_anode = 4'b0111;
        w_blank = BLANK_LZ && (r_digits[15:12] == 4'd0);
      end
    endcase
  end

  // BCD to active-low {a,b,c,d,e,f,g} segment decode.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Registered pins: anode and segments switch together, one cycle after sel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      anode  <= 4'b1111;
      ssdOut <= 7'b1111111;
    end else begin
      anode  <= w_anode;
      ssdOut <= w_blank ? 7'b1111111 : w_seg;
    end
  end

endmodule

// File: tb/tb_score_ssd_driver.sv
// Testbench for score_ssd_driver: two instances (blanking on/off) with
// SCAN_BITS = 4, checked every cycle against a decimal-arithmetic model.
module tb_score_ssd_driver;

  localparam int SB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] score;
  logic [6:0]  ssd_lz, ssd_nb;
  logic [3:0]  an_lz, an_nb;
  logic        ovf_lz, ovf_nb;
  logic        done_lz, done_nb;

  always #5 clk = ~clk;

  score_ssd_driver #(.SCAN_BITS(SB), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .score(score),
    .ssdOut(ssd_lz), .anode(an_lz), .overflow(ovf_lz), .conv_done(done_lz)
  );

  score_ssd_driver #(.SCAN_BITS(SB), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .score(score),
    .ssdOut(ssd_nb), .anode(an_nb), .overflow(ovf_nb), .conv_done(done_nb)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  // Model state: cycle index since reset release, captured and displayed values.
  int         n;
  int         cap;
  int         val;
  bit         ovf;
  logic [3:0] e_an;
  logic [6:0] e_seg_lz, e_seg_nb;
  logic       e_done;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // One clock: advance the model on the edge, then compare just after it.
  task automatic step();
    int sel, d;
    bit blank;
    @(posedge clk);
    if (!reset_n) begin
      n = 0; val = 0; ovf = 1'b0;
      e_an = 4'hF; e_seg_lz = 7'h7F; e_seg_nb = 7'h7F; e_done = 1'b0;
    end else begin
      sel      = (n % (1 << SB)) >> (SB - 2);
      d        = (val / pow10(sel)) % 10;
      blank    = (sel > 0) && (val < pow10(sel));
      e_an     = 4'hF ^ 4'(1 << sel);
      e_seg_lz = blank ? 7'h7F : seg_tab[d];
      e_seg_nb = seg_tab[d];
      if (n % 18 == 17) begin
        val = (cap > 9999) ? 9999 : cap;
        ovf = (cap > 9999);
      end
      if (n % 18 == 0) cap = int'(score);
      e_done = ((n + 1) % 18 == 17);
      n++;
    end
    #1;
    check_val("anode",     {12'b0, an_lz},   {12'b0, e_an});
    check_val("ssd_lz",    {9'b0, ssd_lz},   {9'b0, e_seg_lz});
    check_val("anode_nb",  {12'b0, an_nb},   {12'b0, e_an});
    check_val("ssd_nb",    {9'b0, ssd_nb},   {9'b0, e_seg_nb});
    check_val("overflow",  {15'b0, ovf_lz},  {15'b0, ovf});
    check_val("conv_done", {15'b0, done_lz}, {15'b0, e_done});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    score   = 16'd1234;
    n = 0; cap = 0; val = 0; ovf = 1'b0;

    // Reset held, then release; the model places the first commit at cycle 17.
    run(3);
    reset_n = 1'b1;
    run(40);

    // Leading-zero blanking and saturation cases.
    score = 16'd7;     run(40);
    score = 16'd12000; run(40);
    score = 16'd9999;  run(40);

    // Score change while a conversion is shifting.
    score = 16'd1234;  run(40);
    guard = 0;
    while (n % 18 != 8 && guard < 40) begin step(); guard++; end
    score = 16'd5678;  run(52);

    // Reset asserted mid-SHIFT aborts that conversion.
    score = 16'd4321;
    guard = 0;
    while (n % 18 != 6 && guard < 40) begin step(); guard++; end
    reset_n = 1'b0;    run(2);
    reset_n = 1'b1;    run(40);

    // Randomized scores across digit-count ranges with occasional resets.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       score = 16'($urandom_range(0, 9));
        1:       score = 16'($urandom_range(0, 99));
        2:       score = 16'($urandom_range(0, 9999));
        default: score = 16'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        run(int'($urandom_range(1, 2)));
        reset_n = 1'b1;
      end
      run(int'($urandom_range(1, 40)));
    end
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
